mac_lookup_arb: RTL
===================

Name: mac_lookup_arb

Overview:
- Shares the single MAC learning/lookup table between pNUM_PORTS ingress ports.
- Each port posts one request carrying a source-address index (learn) and a destination-address index (lookup). The block round-robin arbitrates, sequences one table access, waits the table read latency and returns the egress port number to the requester.
- Holds off while the table reports not-ready (aging sweep). Any access interrupted by the table going not-ready is re-issued.

Parameters:
- pNUM_PORTS, 4, number of ingress requesters; also the range of port numbers stored in the table.
- pADDR_WIDTH, 14, width of the hashed SA/DA table index.
- pLOOKUP_LAT, 2, cycles from table write-enable/address to valid read data; minimum 1.
- pSTAT_WIDTH, 16, width of the retry statistics counter.

Ports:
- iclk  in  1  clock.
- irst  in  1  asynchronous active-high reset.
- ireq  in  pNUM_PORTS  per-port request level.
- isa  in  pNUM_PORTS*pADDR_WIDTH  per-port SA index, port p in bits [p*pADDR_WIDTH +: pADDR_WIDTH].
- ida  in  pNUM_PORTS*pADDR_WIDTH  per-port DA index, same packing as isa.
- oack  out  pNUM_PORTS  one-hot, one-cycle completion pulse.
- orsp_pnum  out  $clog2(pNUM_PORTS)  egress port for the acked request.
- orsp_drop  out  1  high with oack when egress port equals requesting port.
- otbl_sa  out  pADDR_WIDTH  table write address.
- otbl_da  out  pADDR_WIDTH  table read address.
- otbl_pnum  out  $clog2(pNUM_PORTS)  port number to learn.
- otbl_wr_en  out  1  table write strobe.
- itbl_pnum  in  $clog2(pNUM_PORTS)  table read data.
- itbl_ready  in  1  table accepts accesses.
- ostat_retry  out  pSTAT_WIDTH  saturating count of aborted accesses.

Behaviour:
- Clocking and reset: one clock, iclk. irst is asynchronous, active-high.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - round-robin pointer 0;
  - lock flag clear.
- All outputs are registered.
- Request rule: a requester holds ireq and its isa/ida slice stable until its oack pulse, then may drop ireq. A request dropped before grant is ignored. Driving ireq high again in the same cycle as oack is a new request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - If itbl_ready=1 and (lock set, or any ireq=1): select the granted port g. When lock is set, g is the locked port. Otherwise g is the first requesting port at or after the pointer, wrapping modulo pNUM_PORTS.
    - Latch isa/ida slices of g into otbl_sa/otbl_da and g into otbl_pnum, then go to ISSUE.
    - If itbl_ready=0, stay in IDLE with no grant.
  - ISSUE:
    - otbl_wr_en=1 for exactly this cycle.
    - Load the wait counter with pLOOKUP_LAT-1 and go to WAIT.
  - WAIT:
    - Decrement the counter.
    - At counter 0, capture itbl_pnum and go to RESP.
  - RESP:
    - oack[g]=1 for one cycle, orsp_pnum = captured value, orsp_drop = (captured value == g).
    - Pointer becomes (g+1) mod pNUM_PORTS, lock clears, return to IDLE.
- Latency and throughput:
  - Grant decision in cycle 0 produces otbl_wr_en in cycle 1 and oack in cycle 2+pLOOKUP_LAT.
  - Back-to-back throughput is one request per 3+pLOOKUP_LAT cycles.
- Abort:
  - itbl_ready=0 sampled in ISSUE or WAIT sends the FSM to IDLE with no oack.
  - Lock sets with g retained; ostat_retry increments, saturating at all-ones.
  - The pointer does not advance.
  - The locked port is re-issued, with its current isa/ida, the first IDLE cycle itbl_ready=1.
- Boundaries:
  - Only one access is in flight at a time.
  - Pointer wrap: from port pNUM_PORTS-1 the pointer goes to 0.
  - All ports requesting: strict rotation 0,1,2,3,0...
  - Single requester: served on every round.
  - otbl_sa/otbl_da/otbl_pnum keep their value outside ISSUE.
  - Reset mid-access: outputs clear immediately; the in-flight request is lost; the requester must still see no oack.

Decomposition:
- Shared package mac_pkg:
  - PNUM_W = $clog2(pNUM_PORTS);
  - FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - a function slicing a packed per-port address bus.
- One sub-module is natural: rr_arbiter, a combinational pick of the first requester at or after a pointer, with valid and index outputs. It is reusable by other port-sharing blocks.

Test Plan:
- Single request: port 2 ireq with sa=0x0010, da=0x0020, table returns 1, pLOOKUP_LAT=2. Required: otbl_wr_en one cycle after grant with otbl_sa=0x0010, otbl_da=0x0020, otbl_pnum=2; oack=4'b0100 at cycle 4 with orsp_pnum=1, orsp_drop=0.
- All four ports requesting continuously: acks appear in order 0,1,2,3,0, spaced 5 cycles apart.
- Self-hit: port 3 request, table returns 3. Required: oack[3]=1 with orsp_drop=1.
- itbl_ready low from reset: no otbl_wr_en while low; when ready rises the first grant goes to port 0.
- itbl_ready drops in WAIT during a port 1 access, with port 2 also requesting. Required: no oack, ostat_retry=1; after ready returns, port 1 is re-issued and acked before port 2.
- irst asserted during WAIT: oack and otbl_wr_en go 0 asynchronously; after release with ireq=4'b1000, port 3 is granted first.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, constants and helpers for the MAC lookup arbiter
package mac_pkg;

    localparam int NUM_PORTS_DEF  = 4;
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int PNUM_W         = $clog2(NUM_PORTS_DEF);

    // Widest packed per-port bus and widest single slice the slicing helper handles
    localparam int MAX_BUS_W  = 1024;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Returns slice idx of a bus packed as idx*width +: width, zero-extended
    function automatic logic [MAX_ADDR_W-1:0] slice_addr(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [MAX_BUS_W-1:0]  w_shift;
        logic [MAX_ADDR_W-1:0] w_mask;
        w_shift = bus >> (idx * width);
        w_mask  = (width >= MAX_ADDR_W) ? '1
                                        : ((MAX_ADDR_W'(1) << width) - MAX_ADDR_W'(1));
        return w_shift[MAX_ADDR_W-1:0] & w_mask;
    endfunction

endpackage

// File: rtl/mac_lookup_arb_if.sv
// rtl/mac_lookup_arb_if.sv - requester, table and statistics signals of the lookup arbiter
interface mac_lookup_arb_if
    import mac_pkg::*;
#(
    parameter int pNUM_PORTS  = NUM_PORTS_DEF,
    parameter int pADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int pSTAT_WIDTH = 16
);
    localparam int lPNUM_W = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;

    // Requester side
    logic [pNUM_PORTS-1:0]             ireq;
    logic [pNUM_PORTS*pADDR_WIDTH-1:0] isa;
    logic [pNUM_PORTS*pADDR_WIDTH-1:0] ida;
    logic [pNUM_PORTS-1:0]             oack;
    logic [lPNUM_W-1:0]                orsp_pnum;
    logic                              orsp_drop;

    // Table side
    logic [pADDR_WIDTH-1:0]            otbl_sa;
    logic [pADDR_WIDTH-1:0]            otbl_da;
    logic [lPNUM_W-1:0]                otbl_pnum;
    logic                              otbl_wr_en;
    logic [lPNUM_W-1:0]                itbl_pnum;
    logic                              itbl_ready;

    // Statistics
    logic [pSTAT_WIDTH-1:0]            ostat_retry;

    modport slave (
        input  ireq, isa, ida, itbl_pnum, itbl_ready,
        output oack, orsp_pnum, orsp_drop, otbl_sa, otbl_da, otbl_pnum, otbl_wr_en,
        output ostat_retry
    );

    modport master (
        output ireq, isa, ida, itbl_pnum, itbl_ready,
        input  oack, orsp_pnum, orsp_drop, otbl_sa, otbl_da, otbl_pnum, otbl_wr_en,
        input  ostat_retry
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first requester at or after a pointer
module rr_arbiter #(
    parameter  int pN = 4,
    localparam int lW = (pN > 1) ? $clog2(pN) : 1
) (
    input  logic [pN-1:0] i_req,
    input  logic [lW-1:0] i_ptr,
    output logic          o_valid,
    output logic [lW-1:0] o_idx
);

    // Scan from the farthest candidate back to the pointer so the nearest requester wins
    always_comb begin
        int w_j;
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = pN - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % pN;
            if (i_req[lW'(w_j)]) begin
                o_valid = 1'b1;
                o_idx   = lW'(w_j);
            end
        end
    end

endmodule

// File: rtl/mac_lookup_arb.sv
// rtl/mac_lookup_arb.sv - round-robin sharing of one MAC learn/lookup table between ingress ports
module mac_lookup_arb
    import mac_pkg::*;
#(
    parameter int pNUM_PORTS  = NUM_PORTS_DEF,
    parameter int pADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int pLOOKUP_LAT = 2,
    parameter int pSTAT_WIDTH = 16
) (
    input  logic             iclk,
    input  logic             irst,
    mac_lookup_arb_if.slave  bif
);

    localparam int lPNUM_W = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;
    // Wait counter only ever holds pLOOKUP_LAT-1 down to 0
    localparam int lCNT_W  = (pLOOKUP_LAT > 1) ? $clog2(pLOOKUP_LAT) : 1;
    localparam logic [lCNT_W-1:0]  lCNT_LOAD = lCNT_W'(pLOOKUP_LAT - 1);
    localparam logic [lPNUM_W-1:0] lLAST     = lPNUM_W'(pNUM_PORTS - 1);

    state_t                  r_state;
    logic [lPNUM_W-1:0]      r_ptr;
    logic [lPNUM_W-1:0]      r_g;
    logic                    r_lock;
    logic [lCNT_W-1:0]       r_cnt;

    logic [pNUM_PORTS-1:0]   r_oack;
    logic [lPNUM_W-1:0]      r_rsp_pnum;
    logic                    r_rsp_drop;
    logic [pADDR_WIDTH-1:0]  r_tbl_sa;
    logic [pADDR_WIDTH-1:0]  r_tbl_da;
    logic [lPNUM_W-1:0]      r_tbl_pnum;
    logic                    r_tbl_wr_en;
    logic [pSTAT_WIDTH-1:0]  r_stat_retry;

    logic                    w_arb_valid;
    logic [lPNUM_W-1:0]      w_arb_idx;
    logic [lPNUM_W-1:0]      w_g;
    logic [pADDR_WIDTH-1:0]  w_sa_sel;
    logic [pADDR_WIDTH-1:0]  w_da_sel;
    logic                    w_abort;

    rr_arbiter #(
        .pN (pNUM_PORTS)
    ) u_rr_arbiter (
        .i_req   (bif.ireq),
        .i_ptr   (r_ptr),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    // An aborted access keeps its port until it is re-issued, ahead of any newcomer
    assign w_g      = r_lock ? r_g : w_arb_idx;
    assign w_sa_sel = pADDR_WIDTH'(slice_addr(MAX_BUS_W'(bif.isa), 32'(w_g), pADDR_WIDTH));
    assign w_da_sel = pADDR_WIDTH'(slice_addr(MAX_BUS_W'(bif.ida), 32'(w_g), pADDR_WIDTH));
    assign w_abort  = !bif.itbl_ready && (r_state == ISSUE || r_state == WAIT);

    // Access sequencer: grant, strobe, wait out the table latency, return the result
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_g          <= '0;
            r_lock       <= 1'b0;
            r_cnt        <= '0;
            r_oack       <= '0;
            r_rsp_pnum   <= '0;
            r_rsp_drop   <= 1'b0;
            r_tbl_sa     <= '0;
            r_tbl_da     <= '0;
            r_tbl_pnum   <= '0;
            r_tbl_wr_en  <= 1'b0;
            r_stat_retry <= '0;
        end else begin
            r_oack      <= '0;
            r_rsp_drop  <= 1'b0;
            r_tbl_wr_en <= 1'b0;
            if (w_abort) begin
                // Table went busy mid-access: drop it, remember the port, count the retry
                r_lock  <= 1'b1;
                r_state <= IDLE;
                if (r_stat_retry != '1) begin
                    r_stat_retry <= r_stat_retry + pSTAT_WIDTH'(1);
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bif.itbl_ready && (r_lock || w_arb_valid)) begin
                            r_g         <= w_g;
                            r_tbl_sa    <= w_sa_sel;
                            r_tbl_da    <= w_da_sel;
                            r_tbl_pnum  <= w_g;
                            r_tbl_wr_en <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        r_cnt   <= lCNT_LOAD;
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        if (r_cnt == '0) begin
                            r_rsp_pnum <= bif.itbl_pnum;
                            r_rsp_drop <= (bif.itbl_pnum == r_g);
                            r_oack     <= pNUM_PORTS'(1) << r_g;
                            r_state    <= RESP;
                        end else begin
                            r_cnt <= r_cnt - lCNT_W'(1);
                        end
                    end
                    RESP: begin
                        r_ptr   <= (r_g == lLAST) ? '0 : r_g + lPNUM_W'(1);
                        r_lock  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bif.oack        = r_oack;
    assign bif.orsp_pnum   = r_rsp_pnum;
    assign bif.orsp_drop   = r_rsp_drop;
    assign bif.otbl_sa     = r_tbl_sa;
    assign bif.otbl_da     = r_tbl_da;
    assign bif.otbl_pnum   = r_tbl_pnum;
    assign bif.otbl_wr_en  = r_tbl_wr_en;
    assign bif.ostat_retry = r_stat_retry;

endmodule
